// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared ids, default widths and read-tag entry type for ram_port_arbiter
package ram_arb_pkg;
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int RD_LAT_DEF = 1;
  typedef struct packed {
    logic vld;
    logic id;
  } tag_t;
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester A/B command and read-return signals plus the shared RAM port
// slave  = arbiter side (takes requests and ram_rd_data, drives grants, read returns, RAM command)
// master = requester/RAM side (the mirror image)
interface ram_port_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req_a, we_a, gnt_a, rd_vld_a;
  logic [ADDR_W-1:0] addr_a;
  logic [DATA_W-1:0] wdata_a, rd_data_a;
  logic              req_b, we_b, gnt_b, rd_vld_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] wdata_b, rd_data_b;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wr_data, ram_rd_data;
  modport slave (
    input  req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b, ram_rd_data,
    output gnt_a, rd_vld_a, rd_data_a, gnt_b, rd_vld_b, rd_data_b,
    output ram_en, ram_we, ram_addr, ram_wr_data
  );
  modport master (
    output req_a, we_a, addr_a, wdata_a, req_b, we_b, addr_b, wdata_b, ram_rd_data,
    input  gnt_a, rd_vld_a, rd_data_a, gnt_b, rd_vld_b, rd_data_b,
    input  ram_en, ram_we, ram_addr, ram_wr_data
  );
endinterface

// File: rtl/rr_arb_2.sv
// rr_arb_2: two-input round-robin / fixed-priority grant with last-grant pointer
// clk, rst_n    : clock, async active-low reset
// req_a, req_b  : requests
// gnt_a, gnt_b  : combinational one-hot-or-zero grants
module rr_arb_2
  import ram_arb_pkg::*;
#(
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);
  logic last_q, last_d;
  // A wins alone, under fixed priority, or when B had the previous grant
  always_comb begin
    gnt_a  = req_a & (~req_b | FIXED_PRI | (last_q == ID_B));
    gnt_b  = req_b & ~gnt_a;
    last_d = gnt_a ? ID_A : gnt_b ? ID_B : last_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= ID_B;
    else        last_q <= last_d;
  end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one block-RAM port between requesters A and B
// clk, rst_n : clock, async active-low reset
// bus        : requester A/B handshakes, read returns and the registered RAM command
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int RD_LAT    = RD_LAT_DEF,
  parameter bit FIXED_PRI = 1'b0
) (
  input logic clk,
  input logic rst_n,
  ram_port_arbiter_if.slave bus
);
  logic              gnt_a, gnt_b;
  logic              en_q, en_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  tag_t              tag_q [RD_LAT+1];
  tag_t              tag_d [RD_LAT+1];
  tag_t              tag_out;
  rr_arb_2 #(.FIXED_PRI(FIXED_PRI)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_a (bus.req_a),
    .req_b (bus.req_b),
    .gnt_a (gnt_a),
    .gnt_b (gnt_b)
  );
  // Address and write data hold when idle; only en/we drop
  always_comb begin
    en_d      = gnt_a | gnt_b;
    we_d      = gnt_a ? bus.we_a : gnt_b ? bus.we_b : 1'b0;
    addr_d    = gnt_a ? bus.addr_a : gnt_b ? bus.addr_b : addr_q;
    wd_d      = gnt_a ? bus.wdata_a : gnt_b ? bus.wdata_b : wd_q;
    tag_d[0]  = '{vld: en_d & ~we_d, id: gnt_b ? ID_B : ID_A};
    for (int i = 1; i <= RD_LAT; i++) tag_d[i] = tag_q[i-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      wd_q   <= '0;
      tag_q  <= '{default: '0};
    end else begin
      en_q   <= en_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      wd_q   <= wd_d;
      tag_q  <= tag_d;
    end
  end
  // Stage 0 is the command cycle, the RAM adds RD_LAT more: the last stage lines up with douta
  assign tag_out         = tag_q[RD_LAT];
  assign bus.gnt_a       = gnt_a;
  assign bus.gnt_b       = gnt_b;
  assign bus.ram_en      = en_q;
  assign bus.ram_we      = we_q;
  assign bus.ram_addr    = addr_q;
  assign bus.ram_wr_data = wd_q;
  assign bus.rd_vld_a    = tag_out.vld & (tag_out.id == ID_A);
  assign bus.rd_vld_b    = tag_out.vld & (tag_out.id == ID_B);
  assign bus.rd_data_a   = bus.ram_rd_data;
  assign bus.rd_data_b   = bus.ram_rd_data;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: three arbiter builds (default, fixed priority, RD_LAT=2) against a behavioural model
module tb_ram_port_arbiter;
  localparam int N = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_a, we_a, req_b, we_b;
  logic [N-1:0] gnt_a, gnt_b, rd_vld_a, rd_vld_b, ram_en, ram_we;
  logic [4:0]   addr_a [N];
  logic [4:0]   addr_b [N];
  logic [4:0]   ram_addr [N];
  logic [7:0]   wdata_a [N];
  logic [7:0]   wdata_b [N];
  logic [7:0]   rd_data_a [N];
  logic [7:0]   rd_data_b [N];
  logic [7:0]   ram_wr_data [N];
  logic [7:0]   ram_rd_data [N];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always #5 clk = ~clk;
  for (genvar k = 0; k < N; k++) begin : g
    ram_port_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();
    ram_port_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(k == 2 ? 2 : 1), .FIXED_PRI(k == 1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    logic [7:0] mem [32];
    logic [7:0] r1 = 8'h00;
    logic [7:0] r2 = 8'h00;
    bit loaded = 1'b0;
    // RAM port model: the first edge (inside reset) preloads mem[i] = i*0x11
    always @(posedge clk) begin
      if (!loaded) begin
        for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 17);
        loaded <= 1'b1;
      end else if (bus.ram_en) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wr_data;
        else            r1 <= mem[bus.ram_addr];
      end
      r2 <= r1;
    end
    assign bus.ram_rd_data = (k == 2) ? r2 : r1;
    assign bus.req_a       = req_a[k];
    assign bus.we_a        = we_a[k];
    assign bus.addr_a      = addr_a[k];
    assign bus.wdata_a     = wdata_a[k];
    assign bus.req_b       = req_b[k];
    assign bus.we_b        = we_b[k];
    assign bus.addr_b      = addr_b[k];
    assign bus.wdata_b     = wdata_b[k];
    assign gnt_a[k]        = bus.gnt_a;
    assign gnt_b[k]        = bus.gnt_b;
    assign rd_vld_a[k]     = bus.rd_vld_a;
    assign rd_vld_b[k]     = bus.rd_vld_b;
    assign rd_data_a[k]    = bus.rd_data_a;
    assign rd_data_b[k]    = bus.rd_data_b;
    assign ram_en[k]       = bus.ram_en;
    assign ram_we[k]       = bus.ram_we;
    assign ram_addr[k]     = bus.ram_addr;
    assign ram_wr_data[k]  = bus.ram_wr_data;
    assign ram_rd_data[k]  = bus.ram_rd_data;
  end
  typedef struct {
    int         due;
    bit         id;
    logic [7:0] d;
  } ev_t;
  ev_t        evq [N][$];
  logic [7:0] ref_mem [N][32];
  bit         last_a [N];
  bit         e_en [N];
  bit         e_we [N];
  logic [4:0] e_addr [N];
  logic [7:0] e_wd [N];
  bit         ga_m [N];
  bit         gb_m [N];
  task automatic chk(string n, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", n, k, cyc, act, exp);
    end
  endtask
  task automatic lit(string n, logic [31:0] act, logic [31:0] exp);
    chk(n, 0, act, exp);
  endtask
  // Reference: rules applied per cycle, reads scheduled as (due cycle, id, data) events
  task automatic model();
    bit ga, gb, va, vb, w;
    logic [4:0] a;
    logic [7:0] d;
    ev_t ev;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        chk("reset_outputs", k, {gnt_a[k], gnt_b[k], ram_en[k], ram_we[k], ram_addr[k],
                                 ram_wr_data[k], rd_vld_a[k], rd_vld_b[k]}, 32'h0);
        last_a[k] = 1'b0;
        e_en[k] = 1'b0; e_we[k] = 1'b0; e_addr[k] = '0; e_wd[k] = '0;
        ga_m[k] = 1'b0; gb_m[k] = 1'b0;
        evq[k].delete();
        continue;
      end
      ga = req_a[k] && (!req_b[k] || k == 1 || !last_a[k]);
      gb = req_b[k] && !ga;
      chk("grant", k, {gnt_a[k], gnt_b[k]}, {ga, gb});
      chk("ram_cmd", k, {ram_en[k], ram_we[k], ram_addr[k], ram_wr_data[k]},
          {e_en[k], e_we[k], e_addr[k], e_wd[k]});
      va = 1'b0; vb = 1'b0; d = '0;
      if (evq[k].size() > 0 && evq[k][0].due == cyc) begin
        ev = evq[k].pop_front();
        va = !ev.id; vb = ev.id; d = ev.d;
      end
      chk("rd_vld", k, {rd_vld_a[k], rd_vld_b[k]}, {va, vb});
      if (va) chk("rd_data_a", k, rd_data_a[k], d);
      if (vb) chk("rd_data_b", k, rd_data_b[k], d);
      chk("rd_bus", k, {rd_data_a[k], rd_data_b[k]}, {ram_rd_data[k], ram_rd_data[k]});
      if (ga || gb) begin
        w = ga ? we_a[k] : we_b[k];
        a = ga ? addr_a[k] : addr_b[k];
        d = ga ? wdata_a[k] : wdata_b[k];
        last_a[k] = ga;
        e_en[k] = 1'b1; e_we[k] = w; e_addr[k] = a; e_wd[k] = d;
        if (w) ref_mem[k][a] = d;
        else   evq[k].push_back('{cyc + 1 + (k == 2 ? 2 : 1), gb, ref_mem[k][a]});
      end else begin
        e_en[k] = 1'b0; e_we[k] = 1'b0;
      end
      ga_m[k] = ga; gb_m[k] = gb;
    end
  endtask
  task automatic set_all(bit ra, bit wa, int aa, int da, bit rb, bit wb, int ab, int db);
    for (int k = 0; k < N; k++) begin
      req_a[k] = ra; we_a[k] = wa; addr_a[k] = 5'(aa); wdata_a[k] = 8'(da);
      req_b[k] = rb; we_b[k] = wb; addr_b[k] = 5'(ab); wdata_b[k] = 8'(db);
    end
  endtask
  // One clock cycle: drive just after the rising edge, check at the falling edge
  task automatic step(bit rn, bit ra, bit wa, int aa, int da, bit rb, bit wb, int ab, int db);
    @(posedge clk); #1;
    rst_n = rn;
    set_all(ra, wa, aa, da, rb, wb, ab, db);
    @(negedge clk);
    model();
  endtask
  task automatic idle(bit rn);
    step(rn, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  function automatic logic [4:0] rnd_addr();
    return 5'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31));
  endfunction
  task automatic drive_rand();
    for (int k = 0; k < N; k++) begin
      if (!req_a[k] || ga_m[k]) begin
        req_a[k] = ($urandom_range(0, 9) < 6);
        we_a[k] = 1'($urandom_range(0, 1));
        addr_a[k] = rnd_addr();
        wdata_a[k] = 8'($urandom);
      end else if ($urandom_range(0, 19) == 0) req_a[k] = 1'b0;
      if (!req_b[k] || gb_m[k]) begin
        req_b[k] = ($urandom_range(0, 9) < 6);
        we_b[k] = 1'($urandom_range(0, 1));
        addr_b[k] = rnd_addr();
        wdata_b[k] = 8'($urandom);
      end else if ($urandom_range(0, 19) == 0) req_b[k] = 1'b0;
    end
  endtask
  initial begin
    for (int k = 0; k < N; k++) for (int i = 0; i < 32; i++) ref_mem[k][i] = 8'(i * 17);
    set_all(0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);
    lit("reset_cmd", {ram_en[0], ram_we[0], rd_vld_a[0], rd_vld_b[0]}, 4'b0000);
    idle(0);
    idle(0);
    // Write then read-back through A
    step(1, 1, 1, 3, 8'h5A, 0, 0, 0, 0);
    lit("wr_grant", {gnt_a[0], gnt_b[0]}, 2'b10);
    step(1, 1, 0, 3, 0, 0, 0, 0, 0);
    lit("rd_grant", {gnt_a[0], gnt_b[0]}, 2'b10);
    lit("cmd_write", {ram_en[0], ram_we[0], ram_addr[0], ram_wr_data[0]}, {2'b11, 5'd3, 8'h5A});
    idle(1);
    lit("cmd_read", {ram_en[0], ram_we[0], ram_addr[0]}, {2'b10, 5'd3});
    idle(1);
    lit("rd_return", {rd_vld_a[0], rd_vld_b[0], rd_data_a[0]}, {2'b10, 8'h5A});
    idle(1);
    lit("rd_return_lat2", {rd_vld_a[2], rd_data_a[2]}, {1'b1, 8'h5A});
    lit("rd_gone", {rd_vld_a[0], rd_vld_b[0]}, 2'b00);
    // Read in flight, then reset: the return must be dropped
    step(1, 1, 0, 3, 0, 0, 0, 0, 0);
    idle(0);
    lit("reset_async", {ram_en[0], rd_vld_a[0], gnt_a[0]}, 3'b000);
    idle(0);
    idle(1);
    lit("dropped_read", {rd_vld_a[0], rd_vld_a[1]}, 2'b00);
    idle(1);
    lit("dropped_read_lat2", rd_vld_a[2], 1'b0);
    // Contention right after reset: A first, then alternate; fixed build always A
    for (int i = 0; i < 8; i++) begin
      step(1, i < 4, 0, 1, 0, i < 6, 0, 2, 0);
      if (i < 6) begin
        lit("rr_grant", {gnt_a[0], gnt_b[0]}, (i < 4 && i % 2 == 0) ? 2'b10 : 2'b01);
        lit("fixed_grant", {gnt_a[1], gnt_b[1]}, (i < 4) ? 2'b10 : 2'b01);
      end
      if (i >= 2)
        lit("rr_return", {rd_vld_a[0], rd_vld_b[0], rd_vld_a[0] ? rd_data_a[0] : rd_data_b[0]},
            (i < 6 && i % 2 == 0) ? {2'b10, 8'h11} : {2'b01, 8'h22});
    end
    // B writes the top address, A reads it next cycle
    step(1, 0, 0, 0, 0, 1, 1, 31, 8'hFF);
    step(1, 1, 0, 31, 0, 0, 0, 0, 0);
    idle(1);
    idle(1);
    lit("raw_top_addr", {rd_vld_a[0], rd_vld_b[0], rd_data_a[0]}, {2'b10, 8'hFF});
    idle(1);
    // RD_LAT=2: B read returns 3 cycles after its grant
    step(1, 0, 0, 0, 0, 1, 0, 0, 0);
    lit("lat2_grant", gnt_b[2], 1'b1);
    idle(1);
    idle(1);
    lit("lat2_early", rd_vld_b[2], 1'b0);
    idle(1);
    lit("lat2_return", {rd_vld_b[2], rd_data_b[2]}, {1'b1, 8'h00});
    idle(1);
    // Random traffic with hold-until-grant requesters and one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (i == 1501 || i == 1502) begin
        rst_n = 1'b0;
        set_all(0, 0, 0, 0, 0, 0, 0, 0);
      end else begin
        rst_n = 1'b1;
        drive_rand();
      end
      @(negedge clk);
      model();
    end
    for (int i = 0; i < 5; i++) idle(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one port of the 32x8 true dual-port block RAM (blk_mem_gen_0, port A or B) between two independent requesters, A and B.
- Arbitrates on a per-cycle basis: round-robin by default, fixed priority optionally.
- Registers the winning command onto the RAM port.
- Tracks in-flight reads so each read is returned only to its issuer with a valid strobe.
- Sits between traffic generators such as ram_rw and the RAM instance.

Parameters:
ADDR_W, 5, RAM address width.
DATA_W, 8, RAM data width.
RD_LAT, 1, RAM read latency in cycles from the sampling edge to valid douta; legal values are 1 or 2.
FIXED_PRI, 0, 0 = round-robin; 1 = A always wins.

Ports:
clk  in  1  single clock for the block and the RAM port.
rst_n  in  1  asynchronous, active-low reset.
req_a  in  1  requester A command valid; held with we/addr/wdata until gnt_a.
we_a  in  1  1 = write, 0 = read.
addr_a  in  ADDR_W  A address.
wdata_a  in  DATA_W  A write data.
gnt_a  out  1  command accepted this cycle (combinational).
rd_vld_a  out  1  read data for A valid this cycle.
rd_data_a  out  DATA_W  A read data.
req_b, we_b, addr_b, wdata_b, gnt_b, rd_vld_b, rd_data_b: same as the A ports, for requester B.
ram_en  out  1  RAM port enable (registered).
ram_we  out  1  RAM write enable (registered).
ram_addr  out  ADDR_W  RAM address (registered).
ram_wr_data  out  DATA_W  RAM write data (registered).
ram_rd_data  in  DATA_W  RAM douta or doutb.

Behaviour:
- Reset (async assert, sync release of effect): all outputs 0, read-tag pipeline cleared, last-grant pointer = B so A wins the first contention. In-flight reads at reset are dropped; no rd_vld after release for them.
- Grant, combinational in cycle t:
  - At most one of gnt_a/gnt_b is high per cycle; gnt_x is high only when req_x is high.
  - Only one requester: it is granted.
  - Both requesting, FIXED_PRI=0: grant the requester not granted last; the pointer updates only on a grant.
  - Both requesting, FIXED_PRI=1: grant A.
  - No requests: no grant; pointer holds.
- Command register, edge ending t:
  - On a grant: ram_en=1, ram_we/addr/wr_data = the winner's values.
  - Without a grant: ram_en=0, ram_we=0; addr/wr_data hold their last value.
- Throughput: one command per cycle, with no bubbles between back-to-back grants.
- Read return:
  - Tag pipeline of depth RD_LAT+1 carries {valid, id}; it is loaded only for granted reads.
  - Read granted in cycle t: rd_vld_x is high exactly in cycle t+1+RD_LAT (t+2 at default) for one cycle.
  - rd_data_a and rd_data_b = ram_rd_data, unregistered, meaningful only while the matching rd_vld is high; otherwise they show the same bus.
  - rd_vld_a and rd_vld_b are never high together.
- Writes produce no rd_vld.
- Read-after-write to the same address from either requester in consecutive grants returns the new data. This depends on the RAM being configured in write-first or no-conflict order, which the block does not check.
- Requester dropping req before grant: legal; no command issued for it.
- Address width: addr passes through unchanged; no bounds check (2^ADDR_W words).
- Fairness: under continuous contention with FIXED_PRI=0, grants strictly alternate A,B,A,B.

Decomposition:
- Package ram_arb_pkg:
  - localparams ID_A=1'b0 and ID_B=1'b1.
  - Default widths.
  - Typedef of the tag entry {vld, id}.
- Sub-module rr_arb_2: two-input round-robin/fixed-priority grant logic plus the last-grant pointer register.
- The top holds the command register and the tag pipeline.

Test Plan:
1. Reset, then A writes addr 3 = 8'h5A, then A reads addr 3 -> gnt_a in each request cycle; ram_en/ram_we/ram_addr show {1,1,3} then {1,0,3}; rd_vld_a high 2 cycles after the read grant with rd_data_a=8'h5A.
2. A and B both hold reads of addr 1 (8'h11) and addr 2 (8'h22) for 4 cycles -> grants A,B,A,B; rd_vld alternates A/B; A sees 8'h11 and B sees 8'h22.
3. FIXED_PRI=1, both requesting continuously -> gnt_a every cycle, gnt_b never; after A drops req, gnt_b in the same cycle.
4. B writes addr 31 = 8'hFF and A reads addr 31 in the next cycle -> A receives 8'hFF; no rd_vld_b.
5. Issue an A read, then assert rst_n=0 one cycle later for 2 cycles -> all outputs 0 immediately; no rd_vld_a after release; the next contention grants A first.
6. RD_LAT=2 build: B reads addr 0 (8'h00) -> rd_vld_b exactly 3 cycles after gnt_b.
